// File: rtl/seg7_scan_if.sv
// Display-bus bundle between a 7-segment driver and the scan decoder.
// The master drives the multiplexed bus; the slave reads it back into codes.
interface seg7_scan_if #(
    parameter int DIGITS = 4
);
    logic [DIGITS-1:0]   sel;
    logic [6:0]          abcdefg;
    logic                err_clr;
    logic [4*DIGITS-1:0] BCD;
    logic                frame_valid;
    logic                err;

    modport master (
        output sel, abcdefg, err_clr,
        input  BCD, frame_valid, err
    );

    modport slave (
        input  sel, abcdefg, err_clr,
        output BCD, frame_valid, err
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Reads a multiplexed 7-segment bus back into one hex nibble per digit.
// A pattern is captured once per stable dwell; a full set of digits yields a frame.
module seg7_scan_decoder #(
    parameter int DIGITS = 4,
    parameter int STABLE = 3
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);
    localparam int RW = $clog2(STABLE + 1);

    typedef enum logic {WAIT, HOLD} state_t;

    state_t              state_reg, state_next;
    logic [RW-1:0]       run_reg, run_next;
    logic [DIGITS+6:0]   prev_reg, sample;
    logic [DIGITS-1:0]   seen_reg, seen_next;
    logic                frame_valid_reg, frame_valid_next;
    logic                err_reg, err_next;
    logic                changed, capture, write_en, sel_onehot, dec_ok;
    logic [3:0]          dec_code;
    logic [3:0]          nibble_reg [DIGITS];
    logic [4*DIGITS-1:0] bcd_flat;

    assign sample     = {bus.sel, bus.abcdefg};
    assign sel_onehot = (bus.sel != '0) && ((bus.sel & (bus.sel - DIGITS'(1))) == '0);

    always_comb begin
        dec_ok   = 1'b1;
        dec_code = 4'h0;
        case (bus.abcdefg)
            7'h7E: dec_code = 4'h0;
            7'h30: dec_code = 4'h1;
            7'h6D: dec_code = 4'h2;
            7'h79: dec_code = 4'h3;
            7'h33: dec_code = 4'h4;
            7'h5B: dec_code = 4'h5;
            7'h5F: dec_code = 4'h6;
            7'h70: dec_code = 4'h7;
            7'h7F: dec_code = 4'h8;
            7'h7B: dec_code = 4'h9;
            7'h77: dec_code = 4'hA;
            7'h1F: dec_code = 4'hB;
            7'h4E: dec_code = 4'hC;
            7'h3D: dec_code = 4'hD;
            7'h4F: dec_code = 4'hE;
            7'h47: dec_code = 4'hF;
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_next       = state_reg;
        run_next         = run_reg;
        seen_next        = seen_reg;
        frame_valid_next = 1'b0;
        err_next         = err_reg & ~bus.err_clr;
        capture          = 1'b0;
        write_en         = 1'b0;

        // run_reg == 0 only right after reset, so the first sample starts a run
        changed = (run_reg == '0) || (sample != prev_reg);
        if (changed)
            run_next = RW'(1);
        else if (run_reg != RW'(STABLE))
            run_next = run_reg + RW'(1);

        case (state_reg)
            WAIT: begin
                if (run_next == RW'(STABLE)) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // with STABLE == 1 a new pattern is already stable on its first edge
                if (changed) begin
                    if (run_next == RW'(STABLE))
                        capture = 1'b1;
                    else
                        state_next = WAIT;
                end
            end
            default: state_next = WAIT;
        endcase

        if (capture && sel_onehot) begin
            if (dec_ok) begin
                write_en  = 1'b1;
                seen_next = seen_reg | bus.sel;
                if (&seen_next) begin
                    frame_valid_next = 1'b1;
                    seen_next        = '0;
                end
            end else begin
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= WAIT;
            run_reg         <= '0;
            prev_reg        <= '0;
            seen_reg        <= '0;
            frame_valid_reg <= 1'b0;
            err_reg         <= 1'b0;
            for (int i = 0; i < DIGITS; i++)
                nibble_reg[i] <= 4'h0;
        end else begin
            state_reg       <= state_next;
            run_reg         <= run_next;
            prev_reg        <= sample;
            seen_reg        <= seen_next;
            frame_valid_reg <= frame_valid_next;
            err_reg         <= err_next;
            for (int i = 0; i < DIGITS; i++)
                if (write_en && bus.sel[i])
                    nibble_reg[i] <= dec_code;
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_bcd
        assign bcd_flat[4*gi +: 4] = nibble_reg[gi];
    end

    assign bus.BCD         = bcd_flat;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.err         = err_reg;
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reader for the multiplexed 7-segment display drive: samples the one-hot digit select and the `abcdefg` segment lines and maps each stable pattern back to a 4-bit hex/BCD code.
- Stores one code per digit and reports a completed frame once every digit has been captured.
- Sits on the display side of the segment encoder. It is used in self-checking benches and for loop-back readout of the display bus.

Parameters:
- DIGITS, 4, number of multiplexed digits (width of `sel`).
- STABLE, 3, consecutive identical samples required before a capture (minimum 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- sel  input  DIGITS  one-hot digit enable; bit i drives digit i.
- abcdefg  input  7  segment lines, active-high; bit 6 = a ... bit 0 = g.
- err_clr  input  1  clears `err` (single-cycle pulse).
- BCD  output  4*DIGITS  captured codes; digit i occupies bits [4i+3:4i].
- frame_valid  output  1  one-cycle pulse when all digits have been captured.
- err  output  1  sticky flag: an undecodable pattern was captured.

Behaviour:
- Single clock domain. All state updates on the rising edge of `clk`. Reset is synchronous and active-high.
- Reset values: `BCD`=0, `frame_valid`=0, `err`=0. The internal seen-mask, run counter and previous sample are all cleared; the FSM goes to WAIT.
- Run length: the count of consecutive edges at which the same `{sel,abcdefg}` is sampled.
  - A differing sample restarts the count at 1.
  - The count saturates at STABLE.
  - After reset the first sample is run 1.
- FSM:
  - WAIT: on the edge where the run reaches STABLE, perform the capture and go to HOLD.
  - HOLD: stay while the input is unchanged, so there is exactly one capture per dwell. Any change in `{sel,abcdefg}` returns to WAIT with run=1.
- Capture is visible immediately after the capturing edge (latency = STABLE edges from the first stable sample). Rules:
  - `sel` not one-hot (zero or multiple bits set): nothing is written and `err` is not set; the dwell is still consumed.
  - `sel` one-hot and the pattern is in the decode table: write the nibble to that digit and set its seen bit.
  - `sel` one-hot and the pattern is not in the table (including blank 0x00): set `err`; the nibble and seen bit are unchanged.
- Decode table (hex pattern -> code):
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7
  - 7F->8, 7B->9, 77->A, 1F->B, 4E->C, 3D->D, 4F->E, 47->F
- Recapturing an already-seen digit before the frame completes overwrites its nibble.
- Frame completion: when a capture makes the seen-mask all ones, `frame_valid`=1 for exactly the following cycle and the seen-mask clears in the same edge. `BCD` holds the full frame and persists until overwritten.
- `err_clr` and a new error on the same edge: set wins, `err` stays 1.
- Reset mid-frame discards all partial progress; no `frame_valid` results from pre-reset captures.
- Width rule: code nibbles are 4 bits, zero-extended; no arithmetic beyond the run counter (clog2(STABLE+1) bits, saturating).

Test Plan:
1. Reset: `rst`=1 for 2 cycles with random inputs -> `BCD`=16'h0000, `frame_valid`=0, `err`=0.
2. Full frame: drive each of the following for 4 cycles: `sel`=0001/79, then 0010/5B, then 0100/7E, then 1000/30 -> `frame_valid` pulses once, on the cycle after the 3rd edge of the last dwell; `BCD`=16'h1053.
3. Glitch rejection: `sel`=0001 with 7F for 2 cycles, then 7B for 3 cycles -> digit0=9, never 8, exactly one capture.
4. Invalid pattern and bad select:
   - 01 on `sel`=0001 for 5 cycles -> `err`=1, seen unchanged, no `frame_valid`; then `err_clr` pulse -> `err`=0.
   - `sel`=0011 or 0000 for 10 cycles -> no write, no `err`.
5. Long dwell and table sweep:
   - 4E on `sel`=0100 held 20 cycles -> exactly one capture, `BCD`[11:8]=C.
   - Sweep all 16 table entries on digit 0 -> each code read back correctly.
6. Reset mid-frame: capture digits 0–2, pulse `rst` for 1 cycle, capture digit 3 -> no `frame_valid`, `BCD`=16'h?000 with only digit 3 written.
